// File: rtl/sme_pkg.sv
// sme_pkg: shared constants for the string-match-engine job sequencer.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default buffer depths, input kind codes, error bit indices, FSM state encoding.
package sme_pkg;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;
  localparam int TIMEOUT_DEF = 1024;

  // in_kind codes
  localparam logic [1:0] KIND_STR = 2'b00;
  localparam logic [1:0] KIND_PAT = 2'b01;
  localparam logic [1:0] KIND_EOJ = 2'b10;
  localparam logic [1:0] KIND_RSV = 2'b11;

  // res_err bit positions
  localparam int ERR_OVF   = 0;
  localparam int ERR_TMO   = 1;
  localparam int ERR_EMPTY = 2;

  typedef enum logic [2:0] {
    ST_COLLECT  = 3'd0,
    ST_SEND_STR = 3'd1,
    ST_SEND_PAT = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_RESULT   = 3'd4
  } state_e;

endpackage

// File: rtl/sme_char_buf.sv
// sme_char_buf: DEPTH x 8-bit character store, one write port, one registered read port.
// Latency: read data appears the cycle after rd_en_i; it reads 0 in any cycle not enabled.
// Backpressure: none; writes and reads are always accepted.
// Ports: clk, reset (sync, active-high); wr_en_i/wr_addr_i/wr_data_i; rd_en_i/rd_addr_i; rd_data_o.
module sme_char_buf
#(
  parameter int DEPTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Storage is never cleared: stale bytes are unreachable once the lengths reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Zero when idle so the two buffers' outputs can simply be OR-ed together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sme_job_sequencer.sv
// sme_job_sequencer: buffers one tagged job, replays string then pattern bursts to the SME, returns its result.
// Latency: first isstring cycle follows the end-of-job transfer; result one cycle after sme_valid or timeout.
// Backpressure: in_ready low outside COLLECT; result held on res_* until res_valid & res_ready.
// Ports: clk/reset; in_valid/in_ready/in_kind/in_data; chardata/isstring/ispattern and
//        sme_valid/sme_match/sme_match_index to/from SME; res_valid/res_ready/res_match/res_index/res_err; busy.
module sme_job_sequencer
  import sme_pkg::*;
#(
  parameter int STR_MAX     = STR_MAX_DEF,
  parameter int PAT_MAX     = PAT_MAX_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_kind,
  input  logic [7:0] in_data,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [2:0] res_err,
  output logic       busy
);

  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int TW  = $clog2(TIMEOUT_CYC);

  localparam logic [SLW-1:0] STR_FULL = SLW'(STR_MAX);
  localparam logic [PLW-1:0] PAT_FULL = PLW'(PAT_MAX);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e         state_q;
  logic [SLW-1:0] str_len_q;
  logic [PLW-1:0] pat_len_q;
  logic [SLW-1:0] idx_q;     // index of the next character to fetch
  logic [TW-1:0]  timer_q;
  logic [2:0]     err_q;
  logic           isstring_q;
  logic           ispattern_q;
  logic           res_valid_q;
  logic           res_match_q;
  logic [4:0]     res_index_q;
  logic [2:0]     res_err_q;

  logic           in_xfer;
  logic           eoj;
  logic           str_wr;
  logic           pat_wr;
  logic           str_more;
  logic           pat_more;
  logic           str_rd_en;
  logic           pat_rd_en;
  logic [PAW-1:0] pat_rd_addr;
  logic [7:0]     str_rd_dat;
  logic [7:0]     pat_rd_dat;
  logic [2:0]     err_empty;
  logic [2:0]     err_tmo;

  assign in_xfer  = in_valid && (state_q == ST_COLLECT);
  assign eoj      = in_xfer && (in_kind == KIND_EOJ);
  assign str_wr   = in_xfer && (in_kind == KIND_STR) && (str_len_q != STR_FULL);
  assign pat_wr   = in_xfer && (in_kind == KIND_PAT) && (pat_len_q != PAT_FULL);
  assign str_more = idx_q < str_len_q;
  assign pat_more = idx_q < SLW'(pat_len_q);

  always_comb begin
    err_empty            = err_q;
    err_empty[ERR_EMPTY] = 1'b1;
    err_tmo              = err_q;
    err_tmo[ERR_TMO]     = 1'b1;
  end

  // Buffer reads are issued one cycle ahead so the registered read data lines up
  // with the registered isstring/ispattern strobes.
  always_comb begin
    str_rd_en   = 1'b0;
    pat_rd_en   = 1'b0;
    pat_rd_addr = '0;
    case (state_q)
      ST_COLLECT: begin
        if (eoj && (pat_len_q != '0)) begin
          if (str_len_q != '0) begin
            str_rd_en = 1'b1;
          end else begin
            pat_rd_en = 1'b1;
          end
        end
      end
      ST_SEND_STR: begin
        if (str_more) begin
          str_rd_en = 1'b1;
        end else begin
          pat_rd_en = 1'b1;   // pattern char 0 follows the last string char with no gap
        end
      end
      ST_SEND_PAT: begin
        if (pat_more) begin
          pat_rd_en   = 1'b1;
          pat_rd_addr = idx_q[PAW-1:0];
        end
      end
      default: ;
    endcase
  end

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (str_wr),
    .wr_addr_i (str_len_q[SAW-1:0]),
    .wr_data_i (in_data),
    .rd_en_i   (str_rd_en),
    .rd_addr_i (idx_q[SAW-1:0]),
    .rd_data_o (str_rd_dat)
  );

  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (pat_wr),
    .wr_addr_i (pat_len_q[PAW-1:0]),
    .wr_data_i (in_data),
    .rd_en_i   (pat_rd_en),
    .rd_addr_i (pat_rd_addr),
    .rd_data_o (pat_rd_dat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_COLLECT;
      str_len_q   <= '0;
      pat_len_q   <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      err_q       <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      res_err_q   <= '0;
    end else begin
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          if (in_valid) begin
            case (in_kind)
              KIND_STR: begin
                if (str_len_q != STR_FULL) str_len_q <= str_len_q + SLW'(1);
                else                       err_q[ERR_OVF] <= 1'b1;
              end
              KIND_PAT: begin
                if (pat_len_q != PAT_FULL) pat_len_q <= pat_len_q + PLW'(1);
                else                       err_q[ERR_OVF] <= 1'b1;
              end
              KIND_EOJ: begin
                if (pat_len_q == '0) begin
                  state_q     <= ST_RESULT;
                  res_valid_q <= 1'b1;
                  res_match_q <= 1'b0;
                  res_index_q <= '0;
                  res_err_q   <= err_empty;
                end else if (str_len_q != '0) begin
                  state_q    <= ST_SEND_STR;
                  isstring_q <= 1'b1;
                  idx_q      <= SLW'(1);
                end else begin
                  // No string: the SME keeps matching against its previous one.
                  state_q     <= ST_SEND_PAT;
                  ispattern_q <= 1'b1;
                  idx_q       <= SLW'(1);
                end
              end
              default: ;
            endcase
          end
        end
        ST_SEND_STR: begin
          if (str_more) begin
            isstring_q <= 1'b1;
            idx_q      <= idx_q + SLW'(1);
          end else begin
            state_q     <= ST_SEND_PAT;
            ispattern_q <= 1'b1;
            idx_q       <= SLW'(1);
          end
        end
        ST_SEND_PAT: begin
          if (pat_more) begin
            ispattern_q <= 1'b1;
            idx_q       <= idx_q + SLW'(1);
          end else begin
            state_q <= ST_WAIT_RES;
            idx_q   <= '0;
            timer_q <= '0;
          end
        end
        ST_WAIT_RES: begin
          // sme_valid is checked first so a strobe on the final cycle still counts.
          if (sme_valid) begin
            state_q     <= ST_RESULT;
            res_valid_q <= 1'b1;
            res_err_q   <= err_q;
            res_match_q <= (err_q == '0) ? sme_match : 1'b0;
            res_index_q <= (err_q == '0) ? sme_match_index : 5'd0;
          end else if (timer_q == TMO_LAST) begin
            state_q     <= ST_RESULT;
            res_valid_q <= 1'b1;
            res_err_q   <= err_tmo;
            res_match_q <= 1'b0;
            res_index_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            state_q     <= ST_COLLECT;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
            res_err_q   <= '0;
            str_len_q   <= '0;
            pat_len_q   <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            err_q       <= '0;
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_COLLECT);
  assign busy      = (state_q != ST_COLLECT);
  assign chardata  = str_rd_dat | pat_rd_dat;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign res_valid = res_valid_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_sme_job_sequencer.sv
// tb_sme_job_sequencer: scoreboard bench for sme_job_sequencer with a scripted SME responder.
// Latency: n/a. Backpressure: res_ready driven by the bench, held low in the timeout job.
// Stimulus pushes expected SME characters and results; monitors pop and compare at negedge.
module tb_sme_job_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_kind;
  logic [7:0] in_data;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_match_index;
  logic       res_valid;
  logic       res_ready;
  logic       res_match;
  logic [4:0] res_index;
  logic [2:0] res_err;
  logic       busy;

  sme_job_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_kind         (in_kind),
    .in_data         (in_data),
    .chardata        (chardata),
    .isstring        (isstring),
    .ispattern       (ispattern),
    .sme_valid       (sme_valid),
    .sme_match       (sme_match),
    .sme_match_index (sme_match_index),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_match       (res_match),
    .res_index       (res_index),
    .res_err         (res_err),
    .busy            (busy)
  );

  typedef struct packed {
    logic        en;
    logic        m;
    logic [4:0]  ix;
    logic [11:0] dly;
  } plan_t;

  typedef struct packed {
    logic       m;
    logic [4:0] ix;
    logic [2:0] err;
  } res_t;

  logic [8:0] exp_sme [$];   // {is_pattern, char}
  res_t       exp_res [$];
  plan_t      plan    [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int str_cnt = 0, pat_cnt = 0, runs = 0;
  int burst_end_cyc = 0;
  bit sme_chk_en = 1'b1;
  logic first_is, first_ip;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // SME stream and result monitor.
  initial begin : monitor
    logic [8:0] e;
    res_t       r;
    logic       act;
    logic       prev_act;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      act = isstring | ispattern;
      if (!reset) begin
        if (isstring)  str_cnt++;
        if (ispattern) pat_cnt++;
        if (act && !prev_act) runs++;
        if (act && sme_chk_en) begin
          if (exp_sme.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sme_unexpected: got kind %0d char %0h required no traffic", ispattern, chardata);
          end else begin
            e = exp_sme.pop_front();
            chk("sme_char", {isstring, ispattern, chardata}, {~e[8], e[8], e[7:0]});
          end
        end
        if (res_valid && res_ready) begin
          if (exp_res.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected: got match %0d idx %0d err %b required no result",
                     res_match, res_index, res_err);
          end else begin
            r = exp_res.pop_front();
            chk("result", {res_match, res_index, res_err}, {r.m, r.ix, r.err});
          end
        end
      end
      prev_act = act;
    end
  end

  // SME model: after each pattern burst, optionally strobe sme_valid after dly cycles.
  initial begin : responder
    plan_t p;
    logic  prev_pat;
    prev_pat        = 1'b0;
    sme_valid       = 1'b0;
    sme_match       = 1'b0;
    sme_match_index = '0;
    forever begin
      @(negedge clk);
      if (prev_pat && !ispattern) begin
        burst_end_cyc = cyc;
        if (plan.size() > 0) begin
          p = plan.pop_front();
          repeat (int'(p.dly)) @(negedge clk);
          if (p.en) begin
            sme_valid       = 1'b1;
            sme_match       = p.m;
            sme_match_index = p.ix;
            @(negedge clk);
            sme_valid       = 1'b0;
            sme_match       = 1'b0;
            sme_match_index = '0;
          end
        end
      end
      prev_pat = ispattern;
    end
  end

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send_byte(input logic [1:0] k, input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_kind  = k;
    in_data  = d;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_wait: got in_ready 0 required 1 within 3000 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic feed(input string s, input string p, input bit rsv, input bit push);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(2'b00, s[i]);
      if (push && i < 32 && p.len() > 0) exp_sme.push_back({1'b0, s[i]});
    end
    if (rsv) send_byte(2'b11, 8'hAA);
    for (int i = 0; i < p.len(); i++) begin
      send_byte(2'b01, p[i]);
      if (push && i < 8) exp_sme.push_back({1'b1, p[i]});
    end
    send_byte(2'b10, 8'h00);
    first_is = isstring;
    first_ip = ispattern;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_res.size() != 0 || exp_sme.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_res.size() != 0 || exp_sme.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results %0d chars pending required 0", exp_res.size(), exp_sme.size());
      exp_res.delete();
      exp_sme.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    int s0, p0, r0, n, t_valid, rv_cnt;
    string s40, p10;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_kind   = 2'b00;
    in_data   = 8'h00;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_sme_out", {isstring, ispattern, chardata}, 0);
    chk("rst_res", {res_match, res_index, res_err}, 0);

    // Job 1: "ab cd" / "cd", SME answers match at index 3
    s0 = str_cnt; p0 = pat_cnt; r0 = runs;
    plan.push_back('{en: 1'b1, m: 1'b1, ix: 5'd3, dly: 12'd2});
    exp_res.push_back('{m: 1'b1, ix: 5'd3, err: 3'b000});
    feed("ab cd", "cd", 1'b1, 1'b1);
    chk("j1_first_isstring", first_is, 1);
    wait_drain();
    chk("j1_str_cycles", str_cnt - s0, 5);
    chk("j1_pat_cycles", pat_cnt - p0, 2);
    chk("j1_single_burst", runs - r0, 1);

    // Job 2: pattern-only "x"
    s0 = str_cnt; p0 = pat_cnt;
    plan.push_back('{en: 1'b1, m: 1'b1, ix: 5'd7, dly: 12'd0});
    exp_res.push_back('{m: 1'b1, ix: 5'd7, err: 3'b000});
    feed("", "x", 1'b0, 1'b1);
    chk("j2_first_ispattern", first_ip, 1);
    wait_drain();
    chk("j2_str_cycles", str_cnt - s0, 0);
    chk("j2_pat_cycles", pat_cnt - p0, 1);

    // Job 3: overflow, 40 string + 10 pattern chars
    s40 = "";
    for (int i = 0; i < 40; i++) s40 = {s40, string'(8'h41 + 8'(i))};
    p10 = "0123456789";
    s0 = str_cnt; p0 = pat_cnt;
    plan.push_back('{en: 1'b1, m: 1'b1, ix: 5'd5, dly: 12'd1});
    exp_res.push_back('{m: 1'b0, ix: 5'd0, err: 3'b001});
    feed(s40, p10, 1'b0, 1'b1);
    wait_drain();
    chk("j3_str_cycles", str_cnt - s0, 32);
    chk("j3_pat_cycles", pat_cnt - p0, 8);

    // Job 4: EOJ with no pattern
    s0 = str_cnt; p0 = pat_cnt;
    exp_res.push_back('{m: 1'b0, ix: 5'd0, err: 3'b100});
    feed("zz", "", 1'b0, 1'b1);
    chk("j4_no_sme", {first_is, first_ip}, 0);
    wait_drain();
    chk("j4_sme_cycles", (str_cnt - s0) + (pat_cnt - p0), 0);

    // Job 5: SME never answers -> timeout, result held while res_ready low
    @(posedge clk); #2 res_ready = 1'b0;
    @(negedge clk);
    plan.push_back('{en: 1'b0, m: 1'b0, ix: 5'd0, dly: 12'd0});
    exp_res.push_back('{m: 1'b0, ix: 5'd0, err: 3'b010});
    feed("q", "q", 1'b0, 1'b1);
    n = 0;
    while (!res_valid && n < 1200) begin
      @(negedge clk);
      n++;
    end
    t_valid = cyc;
    chk("j5_res_valid", res_valid, 1);
    chk("j5_timeout_cycles", t_valid - burst_end_cyc, 1024);
    for (int i = 0; i < 5; i++) begin
      chk("j5_hold_res", {res_valid, res_match, res_index, res_err}, {1'b1, 1'b0, 5'd0, 3'b010});
      chk("j5_hold_in_ready", {in_ready, busy}, 2'b01);
      @(negedge clk);
    end
    @(posedge clk); #2 res_ready = 1'b1;
    wait_drain();
    chk("j5_back_to_collect", in_ready, 1);

    // Job 6: sme_valid on the final timeout cycle wins
    plan.push_back('{en: 1'b1, m: 1'b1, ix: 5'd2, dly: 12'd1023});
    exp_res.push_back('{m: 1'b1, ix: 5'd2, err: 3'b000});
    feed("ab", "b", 1'b0, 1'b1);
    wait_drain();

    // Job 7: reset during the pattern burst
    sme_chk_en = 1'b0;
    feed("ab", "abcd", 1'b0, 1'b0);
    n = 0;
    while (!ispattern && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("j7_in_send_pat", ispattern, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("j7_sme_idle", {isstring, ispattern, chardata}, 0);
    chk("j7_in_ready", {in_ready, busy, res_valid}, 3'b100);
    reset = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid || isstring || ispattern) rv_cnt++;
    end
    chk("j7_no_result", rv_cnt, 0);
    sme_chk_en = 1'b1;

    // Job 8: normal job after the reset
    plan.push_back('{en: 1'b1, m: 1'b1, ix: 5'd0, dly: 12'd3});
    exp_res.push_back('{m: 1'b1, ix: 5'd0, err: 3'b000});
    feed("k", "k", 1'b0, 1'b1);
    wait_drain();
    chk("plan_consumed", plan.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
